wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Write-side master of the integer register file. Merges the in-order pipeline result (ALU/load)
//  and the multi-cycle mul/div unit (MDU) result into the single regfile write port.
//  Tracks MDU destinations still in flight in a scoreboard and reports them as busy to hazard logic.
//  Write port registered: rf_* fires the cycle after a grant; regfile WB forwarding covers read-after-write.
// PARAMETERS
//  XLEN          32  data width
//  NREG          32  architectural registers (index width = $clog2(NREG))
//  STARVE_LIMIT  4   consecutive cycles an MDU result may wait before starve_hold asserts
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous active-high reset
//  pipe_valid       in   1     pipeline result present; no ready, always accepted when rd!=0
//  pipe_rd          in   5     pipeline destination index
//  pipe_data        in   XLEN  pipeline result
//  mdu_issue_valid  in   1     MDU op issued this cycle; marks mdu_issue_rd pending
//  mdu_issue_rd     in   5     destination of issued MDU op
//  mdu_valid        in   1     MDU result available
//  mdu_rd           in   5     MDU result destination
//  mdu_data         in   XLEN  MDU result
//  mdu_ready        out  1     MDU result accepted this cycle (comb)
//  rs1_index        in   5     hazard query
//  rs2_index        in   5     hazard query
//  rs1_busy         out  1     pending[rs1_index] (comb; x0 never busy)
//  rs2_busy         out  1     pending[rs2_index] (comb)
//  rd_busy          out  1     pending[mdu_issue_rd] (comb; WAW check for issue/decode)
//  starve_hold      out  1     registered; pipeline must present pipe_valid=0 while high
//  rf_write_enable  out  1     registered regfile write strobe
//  rf_rd_index      out  5     registered destination
//  rf_write_data    out  XLEN  registered data
// BEHAVIOUR
//  - Reset: rf_write_enable=0, rf_rd_index=0, rf_write_data=0, pending=0, starve count=0, starve_hold=0.
//  - Grant (comb): pipe_win = pipe_valid && pipe_rd!=0. mdu_ready = !pipe_win. A pipe_rd==0 result is dropped
//    and never blocks the MDU. mdu_valid with mdu_rd==0: accepted, no write, no scoreboard change.
//  - Next cycle: rf_write_enable=1 with winner's rd/data; rf_write_enable=0 if no grant. Latency exactly 1.
//  - Scoreboard: pending[r] set on the cycle after mdu_issue_valid (r!=0); cleared on the cycle the
//    registered MDU write is on rf_* (busy drops when regfile forwarding is valid). Set and clear of the same r
//    in one cycle: set wins. Issue while rd_busy: illegal (decode stalls); pending stays 1.
//  - Starvation: counter increments each cycle mdu_valid && !mdu_ready, clears on MDU accept or !mdu_valid,
//    saturates at STARVE_LIMIT. starve_hold=1 from the cycle after count reaches STARVE_LIMIT until the cycle
//    after the MDU accept. If pipe_valid is nevertheless high during hold, pipe still wins (no data loss).
//  - Pipe write to a pending rd is a hazard violation (pipeline must stall on busy); MDU write still clears it.
//  - Reset mid-operation: all pending cleared, in-flight rf_* write discarded; MDU must be flushed externally.
// CONFIGURATION
//  WB_TRACE_EN defined: $display "WB WRITE: x<rd> = <dec> (0x<hex>) src=PIPE|MDU" per rf write, plus
//    $error on issue-while-busy and pipe-write-to-pending. Not defined: no trace/checks, identical logic.
// STRUCTURE
//  Shared package core_pkg: XLEN, NREG, REG_IDX_W, wb_src_e {WB_SRC_PIPE, WB_SRC_MDU}.
//  One sub-module: wb_scoreboard (pending vector, set/clear, three read ports); arbiter+output regs in top.
// TESTING
//  1. pipe_valid, rd=5, data=0x1234 -> next cycle rf_write_enable=1, rf_rd_index=5, rf_write_data=0x1234.
//  2. pipe rd=3 and mdu rd=7 same cycle -> pipe written, mdu_ready=0; next free cycle x7 written, mdu_ready=1.
//  3. issue rd=9 -> rs1_busy=1 for rs1_index=9 from next cycle; MDU result x9 -> busy clears same cycle rf_* shows x9.
//  4. mdu_valid held with pipe_valid 4 cycles (STARVE_LIMIT=4) -> starve_hold=1; pipe drops -> MDU accepted, hold falls.
//  5. pipe_valid rd=0 with mdu_valid rd=2 -> mdu_ready=1, x2 written, no x0 write.
//  6. rst asserted with pending x4 and MDU grant in flight -> next cycle all outputs 0, rs1_busy(4)=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data/regfile widths and writeback source encoding.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_MDU  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU ops: one set port, one clear port, three busy reads.
// With WB_TRACE_EN defined, a fourth read port is added for the pipe-write hazard check.
module wb_scoreboard
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
`ifdef WB_TRACE_EN
  input  logic [REG_IDX_W-1:0] chk_idx,
  output logic                 chk_busy,
`endif
  input  logic [REG_IDX_W-1:0] rd0_idx,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic                 busy0,
  output logic                 busy1,
  output logic                 busy2
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear applied first so a same-cycle set of the same index wins; x0 is never tracked.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy0 = pending_q[rd0_idx];
  assign busy1 = pending_q[rd1_idx];
  assign busy2 = pending_q[rd2_idx];

`ifdef WB_TRACE_EN
  assign chk_busy = pending_q[chk_idx];
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: pipeline result has priority over MDU, registered write port, MDU scoreboard.
// Optional WB_TRACE_EN adds a write trace and hazard-violation checks without changing the logic.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  input  logic                 mdu_issue_valid,
  input  logic [REG_IDX_W-1:0] mdu_issue_rd,
  input  logic                 mdu_valid,
  input  logic [REG_IDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]      mdu_data,
  output logic                 mdu_ready,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 starve_hold,
  output logic                 rf_write_enable,
  output logic [REG_IDX_W-1:0] rf_rd_index,
  output logic [XLEN-1:0]      rf_write_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                 pipe_win;
  logic                 mdu_grant;
  logic                 mdu_wr;
  wb_src_e              src_d;
  logic                 we_d, we_q;
  logic [REG_IDX_W-1:0] rd_d, rd_q;
  logic [XLEN-1:0]      data_d, data_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 hold_d, hold_q;

  // x0 pipeline results are dropped and never block the MDU.
  assign pipe_win  = pipe_valid && (pipe_rd != '0);
  assign mdu_ready = !pipe_win;
  assign mdu_grant = mdu_valid && mdu_ready;
  assign mdu_wr    = mdu_grant && (mdu_rd != '0);

  always_comb begin
    src_d  = WB_SRC_PIPE;
    we_d   = 1'b0;
    rd_d   = '0;
    data_d = '0;
    if (pipe_win) begin
      src_d  = WB_SRC_PIPE;
      we_d   = 1'b1;
      rd_d   = pipe_rd;
      data_d = pipe_data;
    end else if (mdu_wr) begin
      src_d  = WB_SRC_MDU;
      we_d   = 1'b1;
      rd_d   = mdu_rd;
      data_d = mdu_data;
    end
  end

  // Saturating starvation counter; hold tracks the saturated state one cycle later.
  always_comb begin
    cnt_d = '0;
    if (mdu_valid && !mdu_ready) begin
      cnt_d = (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    hold_d = (cnt_d == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_rd_index     = rd_q;
  assign rf_write_data   = data_q;
  assign starve_hold     = hold_q;

  // Clearing on the grant edge makes busy drop exactly when the write appears on rf_*.
`ifdef WB_TRACE_EN
  logic pipe_rd_busy;
`endif

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mdu_issue_valid),
    .set_idx  (mdu_issue_rd),
    .clr_en   (mdu_wr),
    .clr_idx  (mdu_rd),
`ifdef WB_TRACE_EN
    .chk_idx  (pipe_rd),
    .chk_busy (pipe_rd_busy),
`endif
    .rd0_idx  (rs1_index),
    .rd1_idx  (rs2_index),
    .rd2_idx  (mdu_issue_rd),
    .busy0    (rs1_busy),
    .busy1    (rs2_busy),
    .busy2    (rd_busy)
  );

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_d) begin
        $display("WB WRITE: x%0d = %0d (0x%h) src=%s", rd_d, data_d, data_d,
                 (src_d == WB_SRC_PIPE) ? "PIPE" : "MDU");
      end
      if (mdu_issue_valid && (mdu_issue_rd != '0) && rd_busy) begin
        $error("wb_arbiter: MDU issue to busy x%0d", mdu_issue_rd);
      end
      if (pipe_win && pipe_rd_busy) begin
        $error("wb_arbiter: pipe write to pending x%0d", pipe_rd);
      end
    end
  end
`endif

endmodule
